// File: rtl/nbit_alu_pkg.sv
// Shared opcode encodings and flag bundle for the N-bit ALU.
// Imported by the combinational core and the registered top.
package nbit_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD     = 4'b0000,
        OP_SUB     = 4'b0001,
        OP_MUL     = 4'b0010,
        OP_DIV     = 4'b0011,
        OP_AND     = 4'b0100,
        OP_OR      = 4'b0101,
        OP_XOR     = 4'b0110,
        OP_NOR     = 4'b0111,
        OP_NOT     = 4'b1000,
        OP_GT      = 4'b1001,
        OP_LT      = 4'b1010,
        OP_RSVD_B  = 4'b1011,
        OP_LSL     = 4'b1100,
        OP_LSR     = 4'b1101,
        OP_ASR     = 4'b1110,
        OP_RSVD_F  = 4'b1111
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/nbit_alu_core.sv
// Combinational ALU datapath: arithmetic, logic, compare, shifts and Z/N/C/V flags.
// Carry is only meaningful for unsigned arithmetic, overflow only for signed.
module nbit_alu_core
    import nbit_alu_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                signed_mode,
    input  logic [3:0]          opcode,
    output logic [NUM_BITS-1:0] result,
    output alu_flags_t          flags
);

    localparam int W = NUM_BITS;

    alu_op_e             op;
    logic [W:0]          sum;
    logic [W:0]          diff;
    logic [2*W-1:0]      prod_u;
    logic signed [2*W-1:0] prod_s;
    logic [W-1:0]        quot_u;
    logic [W-1:0]        quot_s;
    logic                div_by_zero;
    logic                div_ovf;
    logic                gt;
    logic                lt;
    logic                c;
    logic                v;

    assign op     = alu_op_e'(opcode);
    assign sum    = {1'b0, a} + {1'b0, b};
    // Extra MSB of the difference is the unsigned borrow.
    assign diff   = {1'b0, a} - {1'b0, b};
    assign prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign prod_s = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});

    // Quotients are only selected when the divisor is nonzero and no overflow.
    assign quot_u      = a / b;
    assign quot_s      = $signed(a) / $signed(b);
    assign div_by_zero = (b == '0);
    assign div_ovf     = signed_mode && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);

    assign gt = signed_mode ? ($signed(a) > $signed(b)) : (a > b);
    assign lt = signed_mode ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[W-1:0];
                if (signed_mode) v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
                else             c = sum[W];
            end
            OP_SUB: begin
                result = diff[W-1:0];
                if (signed_mode) v = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
                else             c = diff[W];
            end
            OP_MUL: begin
                result = prod_u[W-1:0];
                // Signed product fits iff it equals the sign extension of its low half.
                if (signed_mode) v = (prod_s != {{W{prod_s[W-1]}}, prod_s[W-1:0]});
                else             c = (prod_u[2*W-1:W] != '0);
            end
            OP_DIV: begin
                if (div_by_zero || div_ovf) v = 1'b1;
                else result = signed_mode ? quot_s : quot_u;
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_NOT:  result = ~a;
            OP_GT:   result = {{(W-1){1'b0}}, gt};
            OP_LT:   result = {{(W-1){1'b0}}, lt};
            OP_LSL: begin
                result = {a[W-2:0], 1'b0};
                c      = a[W-1];
            end
            OP_LSR: begin
                result = {1'b0, a[W-1:1]};
                c      = a[0];
            end
            OP_ASR: begin
                result = {a[W-1], a[W-1:1]};
                c      = a[0];
            end
            default: result = '0;
        endcase
    end

    assign flags.z = (result == '0);
    assign flags.n = signed_mode & result[W-1];
    assign flags.c = c;
    assign flags.v = v;

endmodule

// File: rtl/nbit_alu.sv
// Registered N-bit ALU: one-cycle latency, a new operation accepted every cycle.
// Reset clears result and all flags (Z included) rather than deriving Z from zero.
module nbit_alu
    import nbit_alu_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
    input  logic                signed_mode,
    input  logic [3:0]          opcode,
    output logic [NUM_BITS-1:0] Result,
    output logic                Z,
    output logic                N,
    output logic                C,
    output logic                V
);

    logic [NUM_BITS-1:0] core_result;
    alu_flags_t          core_flags;

    nbit_alu_core #(
        .NUM_BITS (NUM_BITS)
    ) u_core (
        .a           (A),
        .b           (B),
        .signed_mode (signed_mode),
        .opcode      (opcode),
        .result      (core_result),
        .flags       (core_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            Result <= '0;
            Z      <= 1'b0;
            N      <= 1'b0;
            C      <= 1'b0;
            V      <= 1'b0;
        end else begin
            Result <= core_result;
            Z      <= core_flags.z;
            N      <= core_flags.n;
            C      <= core_flags.c;
            V      <= core_flags.v;
        end
    end

endmodule

// File: tb/tb_nbit_alu.sv
// Scoreboard bench for nbit_alu (NUM_BITS=8): directed corner vectors plus random ops
// checked against an integer reference model; flags packed as {Z,N,C,V}.
module tb_nbit_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A, B;
    logic       signed_mode;
    logic [3:0] opcode;
    logic [7:0] Result;
    logic       Z, N, C, V;

    typedef struct {
        logic [7:0] res;
        logic [3:0] fl;
        string      tag;
    } exp_t;

    exp_t scb[$];
    int   checks   = 0;
    int   failures = 0;

    nbit_alu #(.NUM_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .A           (A),
        .B           (B),
        .signed_mode (signed_mode),
        .opcode      (opcode),
        .Result      (Result),
        .Z           (Z),
        .N           (N),
        .C           (C),
        .V           (V)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic sm);
        int ua, ub, sa, sbv, t;
        logic [7:0] r;
        logic c, v;
        exp_t e;
        ua = int'(a); ub = int'(b);
        sa  = a[7] ? ua - 256 : ua;
        sbv = b[7] ? ub - 256 : ub;
        r = 8'd0; c = 1'b0; v = 1'b0; t = 0;
        case (op)
            4'd0: begin
                if (sm) begin t = sa + sbv; v = (t > 127) || (t < -128); end
                else    begin t = ua + ub;  c = (t > 255); end
                r = t[7:0];
            end
            4'd1: begin
                if (sm) begin t = sa - sbv; v = (t > 127) || (t < -128); end
                else    begin t = ua - ub;  c = (ua < ub); end
                r = t[7:0];
            end
            4'd2: begin
                if (sm) begin t = sa * sbv; v = (t > 127) || (t < -128); end
                else    begin t = ua * ub;  c = (t > 255); end
                r = t[7:0];
            end
            4'd3: begin
                if (ub == 0 || (sm && sa == -128 && sbv == -1)) v = 1'b1;
                else begin t = sm ? sa / sbv : ua / ub; r = t[7:0]; end
            end
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = ~(a | b);
            4'd8:  r = ~a;
            4'd9:  r = (sm ? (sa > sbv) : (ua > ub)) ? 8'd1 : 8'd0;
            4'd10: r = (sm ? (sa < sbv) : (ua < ub)) ? 8'd1 : 8'd0;
            4'd12: begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'd13: begin r = {1'b0, a[7:1]}; c = a[0]; end
            4'd14: begin r = {a[7], a[7:1]}; c = a[0]; end
            default: r = 8'd0;
        endcase
        e.res = r;
        e.fl  = {(r == 8'd0), sm & r[7], c, v};
        e.tag = "rand";
        return e;
    endfunction

    task automatic drive(input string tag, input logic r, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input logic [7:0] res, input logic [3:0] fl);
        exp_t e;
        @(negedge clk);
        rst = r; opcode = op; A = a; B = b; signed_mode = sm;
        e.res = res; e.fl = fl; e.tag = tag;
        scb.push_back(e);
    endtask

    // Monitor: each pushed expectation matures one edge after it was driven.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (scb.size() > 0) begin
            e = scb.pop_front();
            check(e.tag, {20'd0, Result, Z, N, C, V}, {20'd0, e.res, e.fl});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t m;
        logic [3:0] rop;
        logic [7:0] ra, rb;
        logic       rsm;
        rst = 1'b1; opcode = 4'd0; A = 8'd0; B = 8'd0; signed_mode = 1'b0;

        drive("rst0", 1, 4'h0, 8'd255, 8'd1, 0, 8'h00, 4'b0000);
        drive("rst1", 1, 4'h8, 8'h00,  8'h00, 1, 8'h00, 4'b0000);

        //              tag       rst op    A       B      sm  Result  ZNCV
        drive("add_u",    0, 4'h0, 8'd255, 8'd1,  0, 8'h00, 4'b1010);
        drive("add_s",    0, 4'h0, 8'd127, 8'd1,  1, 8'h80, 4'b0101);
        drive("sub_u",    0, 4'h1, 8'd0,   8'd1,  0, 8'hFF, 4'b0010);
        drive("sub_s1",   0, 4'h1, 8'h7F,  8'hFF, 1, 8'h80, 4'b0101);
        drive("sub_s2",   0, 4'h1, 8'h80,  8'hFF, 1, 8'h81, 4'b0100);
        drive("mul_s",    0, 4'h2, 8'd127, 8'd2,  1, 8'hFE, 4'b0101);
        drive("mul_u",    0, 4'h2, 8'd127, 8'd2,  0, 8'hFE, 4'b0000);
        drive("mul_s0",   0, 4'h2, 8'h80,  8'd2,  1, 8'h00, 4'b1001);
        drive("div_z",    0, 4'h3, 8'd255, 8'd0,  0, 8'h00, 4'b1001);
        drive("div_ovf",  0, 4'h3, 8'h80,  8'hFF, 1, 8'h00, 4'b1001);
        drive("div_trunc",0, 4'h3, 8'hF9,  8'd2,  1, 8'hFD, 4'b0100);
        drive("div_u",    0, 4'h3, 8'd200, 8'd7,  0, 8'd28, 4'b0000);
        drive("and",      0, 4'h4, 8'd240, 8'd15, 0, 8'h00, 4'b1000);
        drive("or",       0, 4'h5, 8'd240, 8'd15, 0, 8'hFF, 4'b0000);
        drive("xor",      0, 4'h6, 8'd240, 8'd15, 0, 8'hFF, 4'b0000);
        drive("nor",      0, 4'h7, 8'd240, 8'd15, 0, 8'h00, 4'b1000);
        drive("not",      0, 4'h8, 8'd240, 8'd99, 0, 8'h0F, 4'b0000);
        drive("gt_u",     0, 4'h9, 8'd255, 8'd1,  0, 8'h01, 4'b0000);
        drive("lt_s",     0, 4'hA, 8'h80,  8'h7F, 1, 8'h01, 4'b0000);
        drive("gt_s",     0, 4'h9, 8'h7F,  8'hFF, 1, 8'h01, 4'b0000);
        drive("lt_u",     0, 4'hA, 8'h80,  8'h7F, 0, 8'h00, 4'b1000);
        drive("lsl",      0, 4'hC, 8'd128, 8'd5,  0, 8'h00, 4'b1010);
        drive("lsr",      0, 4'hD, 8'd1,   8'd5,  0, 8'h00, 4'b1010);
        drive("asr_s",    0, 4'hE, 8'd128, 8'd5,  1, 8'hC0, 4'b0100);
        drive("asr_u",    0, 4'hE, 8'h81,  8'd0,  0, 8'hC0, 4'b0010);
        drive("rsvd_b",   0, 4'hB, 8'hAA,  8'h55, 1, 8'h00, 4'b1000);
        drive("rsvd_f",   0, 4'hF, 8'hAA,  8'h55, 1, 8'h00, 4'b1000);

        drive("add_pre",  0, 4'h0, 8'd3,   8'd4,  0, 8'd7,  4'b0000);
        drive("rst_mid",  1, 4'h0, 8'd255, 8'd1,  0, 8'h00, 4'b0000);
        drive("post_rst", 0, 4'h1, 8'd5,   8'd9,  1, 8'hFC, 4'b0100);

        for (int i = 0; i < 200; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin ra = 8'h80; rb = 8'hFF; end
            rsm = 1'($urandom_range(0, 1));
            m = model(rop, ra, rb, rsm);
            drive("rand", 0, rop, ra, rb, rsm, m.res, m.fl);
        end

        @(negedge clk);
        @(negedge clk);
        check("drain", 32'(scb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nbit_alu.md
NBIT_ALU -- requirements
Module: nbit_alu

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter: NUM_BITS, default 8, operand/result width (>=2).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 A  input  NUM_BITS  operand A.
REQ-006 B  input  NUM_BITS  operand B.
REQ-007 signed_mode  input  1  1 = two's-complement operands; 0 = unsigned.
REQ-008 opcode  input  4  operation select.
REQ-009 Result  output  NUM_BITS  registered result.
REQ-010 Z, N, C, V  output  1 each  registered zero / negative / carry / overflow flags.

Function
REQ-011 All outputs SHALL be registered; the values for inputs sampled at rising edge k SHALL appear after edge k; latency 1 cycle, new op every cycle, no handshake.
REQ-012 Opcodes: 0000 ADD A+B; 0001 SUB A-B; 0010 MUL (low NUM_BITS of product); 0011 DIV A/B, truncating toward zero.
REQ-013 Opcodes: 0100 AND; 0101 OR; 0110 XOR; 0111 NOR; 1000 NOT A (B ignored).
REQ-014 Opcodes: 1001 GT, Result=1 if A>B else 0; 1010 LT, Result=1 if A<B else 0; both compare signed when signed_mode=1, else unsigned.
REQ-015 Opcodes: 1100 LSL by 1; 1101 LSR by 1, zero fill; 1110 ASR by 1, MSB replicated in either mode; B ignored for all shifts.
REQ-016 Opcodes 1011 and 1111 are reserved: Result=0, Z=1, N=C=V=0.
REQ-017 Z = (Result==0) for every opcode.
REQ-018 N = signed_mode AND Result[MSB]; N=0 whenever signed_mode=0.
REQ-019 ADD/SUB/MUL, signed_mode=0: C = carry out (ADD), borrow A<B (SUB), full product >= 2^NUM_BITS (MUL); V=0.
REQ-020 ADD/SUB/MUL, signed_mode=1: C=0; V = true signed result not representable in NUM_BITS.
REQ-021 DIV: B==0 in either mode SHALL give Result=0, V=1, C=0; signed most-negative / -1 SHALL give Result=0, V=1, C=0; otherwise V=C=0.
REQ-022 Shifts: C = bit shifted out (MSB for LSL, LSB for LSR/ASR); V=0.
REQ-023 Logic, NOT, compare and reserved ops: C=0, V=0.

Reset
REQ-024 While rst=1 at a rising edge, Result=0 and Z=N=C=V=0 on the next cycle (Z=0 in reset, not derived from Result).
REQ-025 First edge with rst=0 SHALL register the current inputs normally; an operation sampled during reset SHALL be discarded.

Structure
REQ-026 Opcode constants (ADD..ASR, reserved) SHALL live in a shared package, e.g. alu_pkg.
REQ-027 Combinational datapath and flag logic SHALL be one sub-module nbit_alu_core; nbit_alu adds only the output register and reset.

Verification (NUM_BITS=8, one clock after apply)
REQ-028 ADD unsigned 255+1 -> Result 0, Z1 N0 C1 V0; ADD signed 127+1 -> Result 0x80, Z0 N1 C0 V1.
REQ-029 SUB unsigned 0-1 -> 255, Z0 N0 C1 V0; SUB signed 0x7F-0xFF -> 0x80, N1 C0 V1; SUB signed 0x80-0xFF -> 0x81, N1 C0 V0.
REQ-030 MUL signed 127*2 -> 0xFE, N1 V1 C0; MUL unsigned 127*2 -> 254, all flags 0; MUL signed 0x80*2 -> 0, Z1 V1.
REQ-031 DIV unsigned 255/0 -> 0, Z1 V1; DIV signed 0x80/0xFF -> 0, Z1 V1.
REQ-032 Logic/compare (unsigned): 240 AND 15 -> 0 Z1; OR/XOR -> 255; NOR -> 0; NOT 240 -> 15; GT 255,1 -> 1; LT signed 0x80,0x7F -> 1; GT signed 0x7F,0xFF -> 1.
REQ-033 Shifts: LSL 128 -> 0, Z1 C1; LSR 1 -> 0, Z1 C1; ASR signed 128 -> 192, N1 C0; assert rst mid-stream -> all outputs 0 next cycle.
